// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and helpers for the folded CORDIC engine.
// No ports: holds widths, X0, the Q2.19 arctan table and the FSM states.
package cordic_pkg;

  localparam int CORDIC_WL     = 21;
  localparam int CORDIC_N_ITER = 17;

  localparam logic [20:0] X0_Q219 =
    21'b00_1001101101110100111;

  localparam int ALPHA_N = 17;

  // atan(2^-i) in Q2.19, rounded to nearest
  localparam logic [20:0] ALPHA_Q219 [ALPHA_N] = '{
    21'd411775, 21'd243085, 21'd128439,
    21'd65198,  21'd32725,  21'd16379,
    21'd8191,   21'd4096,   21'd2048,
    21'd1024,   21'd512,    21'd256,
    21'd128,    21'd64,     21'd32,
    21'd16,     21'd8
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Re-scale a positive Q2.19 constant to Q2.(wl-2)
  function automatic logic [63:0] q219_scale(
    input logic [20:0] v,
    input int          wl
  );
    logic [63:0] t;
    t = {43'd0, v};
    if (wl >= 21) return t << (wl - 21);
    else          return t >> (21 - wl);
  endfunction

endpackage

// File: rtl/cordic_alpha_rom.sv
// Combinational micro-rotation angle lookup, alpha = atan(2^-idx).
// Ports: idx (iteration index) -> alpha (Q2.(WORD_LENGTH-2)); 0 past table.
module cordic_alpha_rom
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH = CORDIC_WL,
  parameter int CNT_W       = 5
) (
  input  logic [CNT_W-1:0]       idx,
  output logic [WORD_LENGTH-1:0] alpha
);

  always_comb begin
    alpha = '0;
    if (int'(idx) < ALPHA_N)
      alpha = WORD_LENGTH'(
        q219_scale(ALPHA_Q219[idx], WORD_LENGTH));
  end

endmodule

// File: rtl/cordic_stage.sv
// One combinational CORDIC rotation-mode micro-rotation.
// Ports: x/y/z, alpha, iteration in -> x_next/y_next/z_next out.
module cordic_stage #(
  parameter int WORD_LENGTH = 21,
  parameter int CNT_W       = 5
) (
  input  logic signed [WORD_LENGTH-1:0] x,
  input  logic signed [WORD_LENGTH-1:0] y,
  input  logic signed [WORD_LENGTH-1:0] z,
  input  logic signed [WORD_LENGTH-1:0] alpha,
  input  logic        [CNT_W-1:0]       iteration,
  output logic signed [WORD_LENGTH-1:0] x_next,
  output logic signed [WORD_LENGTH-1:0] y_next,
  output logic signed [WORD_LENGTH-1:0] z_next
);

  logic signed [WORD_LENGTH-1:0] xs;
  logic signed [WORD_LENGTH-1:0] ys;

  assign xs = x >>> iteration;
  assign ys = y >>> iteration;

  // Rotate toward z = 0; z >= 0 rotates counter-clockwise
  always_comb begin
    if (!z[WORD_LENGTH-1]) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - alpha;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + alpha;
    end
  end

endmodule

// File: rtl/fixed_to_fp.sv
// Signed Q2.(WORD_LENGTH-2) to IEEE-754 single (exact for WORD_LENGTH<=24).
// Ports: fixed (WORD_LENGTH signed) -> fp (32-bit float).
module fixed_to_fp #(
  parameter int WORD_LENGTH = 21
) (
  input  logic signed [WORD_LENGTH-1:0] fixed,
  output logic [31:0]                   fp
);

  localparam int FRAC = WORD_LENGTH - 2;

  logic [WORD_LENGTH-1:0] mag;
  logic [22:0]            mant;
  logic [7:0]             e;
  int                     p;

  always_comb begin
    mag = fixed[WORD_LENGTH-1] ? -fixed : fixed;
    p = 0;
    for (int i = 0; i < WORD_LENGTH; i++)
      if (mag[i]) p = i;
    // Align leading one to bit 23; the cast drops it (hidden bit)
    if (p < 23)
      mant = 23'({23'd0, mag} << (23 - p));
    else
      mant = 23'(mag >> (p - 23));
    e  = 8'(p - FRAC + 127);
    fp = (mag == '0) ? 32'd0
                     : {fixed[WORD_LENGTH-1], e, mant};
  end

endmodule

// File: rtl/fp_to_fixed.sv
// IEEE-754 single to signed Q2.(WORD_LENGTH-2), truncating magnitude.
// Ports: fp (32-bit float) -> fixed (WORD_LENGTH signed).
module fp_to_fixed #(
  parameter int WORD_LENGTH = 21
) (
  input  logic [31:0]                   fp,
  output logic signed [WORD_LENGTH-1:0] fixed
);

  localparam int FRAC = WORD_LENGTH - 2;

  logic [7:0]             e;
  logic [23:0]            mant;
  logic [WORD_LENGTH-1:0] mag;
  int                     sh;

  always_comb begin
    e    = fp[30:23];
    mant = {1'b1, fp[22:0]};
    // value * 2^FRAC = mant * 2^(e - 150 + FRAC)
    sh   = 150 - FRAC - int'(e);
    if (e == 8'd0)
      mag = '0;
    else if (sh >= 0)
      mag = WORD_LENGTH'(mant >> sh);
    else
      mag = WORD_LENGTH'(mant) << (-sh);
    fixed = fp[31] ? -mag : mag;
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Folded cosine engine: one CORDIC stage reused for N_ITERATIONS cycles.
// Ports: clk, rst (async low); in/in_valid/in_ready; out/out_valid/out_ready; busy.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH  = CORDIC_WL,
  parameter int N_ITERATIONS = CORDIC_N_ITER,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_ITERATIONS - 1);

  localparam logic signed [WORD_LENGTH-1:0] X0 =
    WORD_LENGTH'(q219_scale(X0_Q219, WORD_LENGTH));

  state_t state;

  logic signed [WORD_LENGTH-1:0] x;
  logic signed [WORD_LENGTH-1:0] y;
  logic signed [WORD_LENGTH-1:0] z;
  logic signed [WORD_LENGTH-1:0] x_n;
  logic signed [WORD_LENGTH-1:0] y_n;
  logic signed [WORD_LENGTH-1:0] z_n;
  logic signed [WORD_LENGTH-1:0] z_load;
  logic signed [WORD_LENGTH-1:0] alpha;
  logic [CNT_W-1:0]              iter;
  logic [31:0]                   out_n;

  // Never depends on in_valid
  assign in_ready = (state == IDLE) |
                    ((state == DONE) & out_ready);

  fp_to_fixed #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_f2x (
    .fp   (in),
    .fixed(z_load)
  );

  cordic_alpha_rom #(
    .WORD_LENGTH(WORD_LENGTH),
    .CNT_W      (CNT_W)
  ) u_rom (
    .idx  (iter),
    .alpha(alpha)
  );

  cordic_stage #(
    .WORD_LENGTH(WORD_LENGTH),
    .CNT_W      (CNT_W)
  ) u_stage (
    .x        (x),
    .y        (y),
    .z        (z),
    .alpha    (alpha),
    .iteration(iter),
    .x_next   (x_n),
    .y_next   (y_n),
    .z_next   (z_n)
  );

  fixed_to_fp #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_x2f (
    .fixed(x_n),
    .fp   (out_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      out       <= 32'h0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= X0;
            y     <= '0;
            z     <= z_load;
            iter  <= '0;
            state <= ITER;
            busy  <= 1'b1;
          end
        end
        ITER: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (iter == LAST) begin
            out       <= out_n;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              // Drain and reload on the same edge
              x     <= X0;
              y     <= '0;
              z     <= z_load;
              iter  <= '0;
              state <= ITER;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: reset, latency, accuracy,
// backpressure, back-to-back and mid-operation reset.
module tb_cordic_iter_ctrl;

  localparam logic [31:0] F_ZERO = 32'h00000000;
  localparam logic [31:0] F_ONE  = 32'h3F800000;
  localparam logic [31:0] F_PI6  = 32'h3F060A92;
  localparam logic [31:0] F_NPI4 = 32'hBF490FDB;
  localparam logic [31:0] F_PI3  = 32'h3F860A92;
  localparam logic [31:0] C_PI6  = 32'h3F5DB3D7;
  localparam logic [31:0] C_PI4  = 32'h3F3504F3;
  localparam logic [31:0] C_PI3  = 32'h3F000000;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int tests;
  int fails;

  cordic_iter_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Relative error within 2^-16 of the reference
  function automatic bit close(input logic [31:0] g,
                               input logic [31:0] e);
    real gr, er, d;
    if ($isunknown(g)) return 1'b0;
    gr = $bitstoshortreal(g);
    er = $bitstoshortreal(e);
    d  = gr - er;
    if (d < 0.0) d = -d;
    return d <= er / 65536.0;
  endfunction

  // Accept one angle, then wait (bounded) for out_valid
  task automatic run_op(input  logic [31:0] a,
                        output int          lat,
                        output int          bc,
                        output logic [31:0] r);
    din      = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    bc  = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bc++;
      tick();
      lat++;
    end
    r = dout;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    din       = F_PI6;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (dout !== 32'h0 || out_valid !== 1'b0 ||
          busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_state: out=%h ov=%b busy=%b, want 0/0/0",
                 dout, out_valid, busy);
      end
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_accept: busy=%b ov=%b want 0/0",
               busy, out_valid);
    end
  endtask

  task automatic test_single();
    int lat, bc;
    logic [31:0] r;
    out_ready = 1'b1;
    run_op(F_ZERO, lat, bc, r);
    tests++;
    if (lat !== 17) begin
      fails++;
      $display("FAIL single_latency: got %0d want 17", lat);
    end
    tests++;
    if (bc !== 17) begin
      fails++;
      $display("FAIL single_busy: got %0d cycles want 17", bc);
    end
    tests++;
    if (!close(r, F_ONE)) begin
      fails++;
      $display("FAIL single_cos0: got %h want ~%h", r, F_ONE);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_drain: ov=%b ir=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_accuracy();
    int lat, bc;
    logic [31:0] r;
    out_ready = 1'b1;
    run_op(F_PI6, lat, bc, r);
    tests++;
    if (lat !== 17 || !close(r, C_PI6)) begin
      fails++;
      $display("FAIL acc_pi6: got %h lat %0d want ~%h lat 17",
               r, lat, C_PI6);
    end
    tick();
    run_op(F_NPI4, lat, bc, r);
    tests++;
    if (lat !== 17 || !close(r, C_PI4)) begin
      fails++;
      $display("FAIL acc_npi4: got %h lat %0d want ~%h lat 17",
               r, lat, C_PI4);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, bc;
    logic [31:0] r;
    out_ready = 1'b0;
    run_op(F_PI6, lat, bc, r);
    tests++;
    if (lat !== 17 || !close(r, C_PI6)) begin
      fails++;
      $display("FAIL bp_first: got %h lat %0d want ~%h lat 17",
               r, lat, C_PI6);
    end
    din      = F_ZERO;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (out_valid !== 1'b1 || dout !== r ||
          in_ready !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: ov=%b out=%h ir=%b busy=%b want 1/%h/0/0",
                 i, out_valid, dout, in_ready, busy, r);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: busy=%b ov=%b want 1/0",
               busy, out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    tests++;
    if (lat !== 17 || !close(dout, F_ONE)) begin
      fails++;
      $display("FAIL bp_second: got %h lat %0d want ~%h lat 17",
               dout, lat, F_ONE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ang [4];
    logic [31:0] exp [4];
    int lat, nres;
    ang = '{F_ZERO, F_PI6, F_NPI4, F_PI3};
    exp = '{F_ONE, C_PI6, C_PI4, C_PI3};
    nres      = 0;
    out_ready = 1'b1;
    din       = ang[0];
    in_valid  = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) din = ang[i+1];
      lat = 0;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      if (out_valid) nres++;
      tests++;
      if (lat !== 17 || !close(dout, exp[i])) begin
        fails++;
        $display("FAIL b2b_result[%0d]: got %h lat %0d want ~%h lat 17",
                 i, dout, lat, exp[i]);
      end
      if (i == 3) in_valid = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b0 || busy !== (i < 3)) begin
        fails++;
        $display("FAIL b2b_handover[%0d]: ov=%b busy=%b want 0/%b",
                 i, out_valid, busy, i < 3);
      end
    end
    tests++;
    if (nres !== 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 4", nres);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    logic [31:0] r;
    out_ready = 1'b1;
    din       = F_PI6;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        dout !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: ov=%b busy=%b out=%h want 0/0/0",
               out_valid, busy, dout);
    end
    tick();
    tick();
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL mid_no_output: got %0d valid cycles want 0",
               seen);
    end
    run_op(F_ZERO, lat, bc, r);
    tests++;
    if (lat !== 17 || !close(r, F_ONE)) begin
      fails++;
      $display("FAIL mid_recover: got %h lat %0d want ~%h lat 17",
               r, lat, F_ONE);
    end
    tick();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    din       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_accuracy();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
